// File: rtl/fractal_cu_sync_if.sv
// CU <-> fractal_cu_sync bundle: barrier request/response handshake plus the
// sync/wake/error port facing the first fractal_sync level.
interface fractal_cu_sync_if #(
    parameter int LVL_WIDTH = 3
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [LVL_WIDTH-1:0] req_level_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic                 rsp_error_o;
    logic                 rsp_timeout_o;
    logic                 sync_o;
    logic [LVL_WIDTH-1:0] level_o;
    logic                 wake_i;
    logic                 error_i;
    logic                 stray_o;

    modport slave (
        input  req_valid_i, req_level_i, rsp_ready_i, wake_i, error_i,
        output req_ready_o, rsp_valid_o, rsp_error_o, rsp_timeout_o,
        output sync_o, level_o, stray_o
    );

    modport master (
        output req_valid_i, req_level_i, rsp_ready_i, wake_i, error_i,
        input  req_ready_o, rsp_valid_o, rsp_error_o, rsp_timeout_o,
        input  sync_o, level_o, stray_o
    );
endinterface

// File: rtl/fractal_cu_sync.sv
// CU-side barrier port: one request at a time becomes a single sync pulse to
// the fractal tree, then waits for wake/error (or timeout) and answers the CU.
module fractal_cu_sync #(
    parameter int LEVELS         = 2,
    parameter int LVL_WIDTH      = LEVELS + 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    fractal_cu_sync_if.slave   bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RSP} state_t;

    state_t               r_state, w_state_n;
    logic                 r_err, w_err_n;
    logic                 r_tmo, w_tmo_n;
    logic [CNT_W-1:0]     r_cnt, w_cnt_n;
    logic [LVL_WIDTH-1:0] r_level;
    logic                 r_stray;
    logic                 w_legal;
    logic                 w_expired;

    assign w_legal   = (bus.req_level_i != '0) && (bus.req_level_i <= LVL_WIDTH'(LEVELS));
    assign w_expired = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_MAX);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b0;
            r_tmo   <= 1'b0;
            r_cnt   <= '0;
            r_stray <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_err   <= w_err_n;
            r_tmo   <= w_tmo_n;
            r_cnt   <= w_cnt_n;
            r_stray <= r_stray | ((bus.wake_i | bus.error_i) & (r_state != ST_WAIT));
        end
    end

    // Level is pure payload; it is only observed while the FSM sits in REQ.
    always_ff @(posedge clk_i) begin
        if (r_state == ST_IDLE && bus.req_valid_i) begin
            r_level <= bus.req_level_i;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_err_n   = r_err;
        w_tmo_n   = r_tmo;
        w_cnt_n   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    if (w_legal) begin
                        w_state_n = ST_REQ;
                    end else begin
                        w_state_n = ST_RSP;
                        w_err_n   = 1'b1;
                        w_tmo_n   = 1'b0;
                    end
                end
            end
            ST_REQ: begin
                w_cnt_n   = '0;
                w_state_n = ST_WAIT;
            end
            ST_WAIT: begin
                // Tree events outrank an expiry landing in the same cycle.
                if (bus.error_i || bus.wake_i) begin
                    w_state_n = ST_RSP;
                    w_err_n   = bus.error_i;
                    w_tmo_n   = 1'b0;
                end else if (w_expired) begin
                    w_state_n = ST_RSP;
                    w_err_n   = 1'b1;
                    w_tmo_n   = 1'b1;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            ST_RSP: begin
                if (bus.rsp_ready_i) begin
                    w_state_n = ST_IDLE;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    assign bus.req_ready_o   = (r_state == ST_IDLE);
    assign bus.rsp_valid_o   = (r_state == ST_RSP);
    assign bus.rsp_error_o   = r_err & (r_state == ST_RSP);
    assign bus.rsp_timeout_o = r_tmo & (r_state == ST_RSP);
    assign bus.sync_o        = (r_state == ST_REQ);
    assign bus.level_o       = (r_state == ST_REQ) ? r_level : '0;
    assign bus.stray_o       = r_stray;
endmodule
